// File: rtl/conv_feeder.sv
// conv_feeder: builds a stride-1 sliding window of samples and hands window plus kernel
// to an external convolution operator. Define CONV_FEEDER_FLUSH_EN to add the flush input.
package Conv;
  parameter int LEN   = 4;
  parameter int WIDTH = 64;
  parameter int CNT_W = $clog2(LEN + 1);
  typedef logic [LEN-1:0][WIDTH-1:0] data_vector;
  typedef logic [2*WIDTH-1:0]        result_t;
endpackage

module conv_feeder (
  input  logic                   clk,
  input  logic                   rst,
`ifdef CONV_FEEDER_FLUSH_EN
  input  logic                   flush,
`endif
  input  Conv::data_vector       kernel_in,
  input  logic                   kernel_load,
  input  logic [Conv::WIDTH-1:0] sample_in,
  input  logic                   sample_valid,
  output logic                   sample_ready,
  output Conv::data_vector       conv_kernel,
  output Conv::data_vector       conv_data,
  output logic                   conv_valid,
  input  logic                   conv_ready,
  input  Conv::result_t          op_result,
  input  logic                   op_valid,
  output logic                   op_ready,
  output Conv::result_t          result_out,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [Conv::CNT_W-1:0] win_count
);
  localparam int          LEN  = Conv::LEN;
  localparam int          CW   = Conv::CNT_W;
  localparam logic [CW-1:0] FULL = CW'(Conv::LEN);

  typedef enum logic [1:0] {FILL, ISSUE, WAIT, DRAIN} state_t;
  state_t state, state_next;

  Conv::data_vector window;
  logic             ready_en;
  logic             sample_fire, conv_fire, op_fire, result_fire;
  logic             flush_fill;
  logic [CW-1:0]    count_next;

  // sample_ready stays low until the first edge after reset release
  always_comb begin
    sample_ready = 1'b0;
    conv_valid   = 1'b0;
    op_ready     = 1'b0;
    result_valid = 1'b0;
    case (state)
      FILL:    sample_ready = ready_en;
      ISSUE:   conv_valid   = 1'b1;
      WAIT:    op_ready     = 1'b1;
      DRAIN:   result_valid = 1'b1;
      default: ;
    endcase
  end

  assign sample_fire = sample_valid && sample_ready;
  assign conv_fire   = conv_valid && conv_ready;
  assign op_fire     = op_valid && op_ready;
  assign result_fire = result_valid && result_ready;
  assign conv_data   = window;

`ifdef CONV_FEEDER_FLUSH_EN
  assign flush_fill = flush && (state == FILL);
`else
  assign flush_fill = 1'b0;
`endif

  // a flush restarts the count; a sample on the same edge becomes the first entry
  always_comb begin
    count_next = win_count;
    if (flush_fill)
      count_next = sample_fire ? CW'(1) : '0;
    else if (sample_fire && (win_count != FULL))
      count_next = win_count + 1'b1;
  end

  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (sample_fire && (count_next == FULL)) state_next = ISSUE;
      ISSUE:   if (conv_fire)   state_next = WAIT;
      WAIT:    if (op_fire)     state_next = DRAIN;
      DRAIN:   if (result_fire) state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FILL;
      ready_en <= 1'b0;
    end else begin
      state    <= state_next;
      ready_en <= 1'b1;
    end
  end

  // window shifts toward index 0, so window[0] always holds the oldest sample
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      window      <= '0;
      win_count   <= '0;
      conv_kernel <= '0;
      result_out  <= '0;
    end else begin
      win_count <= count_next;
      if (sample_fire) begin
        for (int k = 0; k < LEN - 1; k++)
          window[k] <= flush_fill ? '0 : window[k+1];
        window[LEN-1] <= sample_in;
      end else if (flush_fill) begin
        window <= '0;
      end
      if ((state == FILL) && kernel_load)
        conv_kernel <= kernel_in;
      if (op_fire)
        result_out <= op_result;
    end
  end

endmodule
